beta_mem_arbiter: RTL

BETA_MEM_ARBITER -- requirements
Module: beta_mem_arbiter

---
 rtl/beta_pkg.sv | 13 +
 rtl/beta_fetch_buffer.sv | 47 ++++
 rtl/beta_mem_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/beta_pkg.sv
// Shared types and constants for the beta memory arbiter.
package beta_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DACC   = 2'd2
  } state_e;

  // Word-granular address compare: byte offset within a 32-bit word is ignored.
  localparam logic [63:0] WORD_MASK = ~64'h3;

endpackage

// File: rtl/beta_fetch_buffer.sv
// One-entry instruction fetch buffer: filled by clean fetch acks, dropped by
// a completed data write to the same word.
module beta_fetch_buffer
  import beta_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [AW-1:0] i_load_addr,
  input  logic [DW-1:0] i_load_data,
  input  logic          i_inv,
  input  logic [AW-1:0] i_inv_addr,
  input  logic [AW-1:0] i_lookup_addr,
  output logic          o_hit,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic [AW-1:0] w_mask;
  logic          w_inv_hit;

  assign w_mask    = WORD_MASK[AW-1:0];
  assign w_inv_hit = r_valid && (((r_addr ^ i_inv_addr) & w_mask) == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_addr  <= i_load_addr;
      r_data  <= i_load_data;
    end else if (i_inv && w_inv_hit) begin
      r_valid <= 1'b0;
    end
  end

  assign o_hit  = r_valid && (r_addr == i_lookup_addr);
  assign o_data = r_data;

endmodule

// File: rtl/beta_mem_arbiter.sv
// Arbitrates instruction fetches and data accesses onto a single-outstanding
// memory port; data wins except that a fetch always follows a data access.
module beta_mem_arbiter
  import beta_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  // instruction side
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_data,
  output logic          i_ready,
  output logic          i_fault,
  // data side
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_re,
  input  logic          d_we,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          d_fault,
  // memory side
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  input  logic          mem_fault
);

  state_e        r_state, w_next;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_re, r_we;

  logic          w_hit;
  logic [DW-1:0] w_buf_data;
  logic          w_dreq, w_fetch_ack, w_fetch_match, w_dacc_ack, w_imiss, w_grant;

  assign w_dreq        = d_re | d_we;
  assign w_fetch_ack   = (r_state == IFETCH) && mem_ack;
  assign w_dacc_ack    = (r_state == DACC) && mem_ack;
  // A redirected fetch still completes, but only answers the core if it matches.
  assign w_fetch_match = w_fetch_ack && (r_addr == i_addr);
  assign w_imiss       = !w_hit && !w_fetch_match;

  beta_fetch_buffer #(.AW(AW), .DW(DW)) u_fbuf (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_fetch_ack && !mem_fault),
    .i_load_addr   (r_addr),
    .i_load_data   (mem_rdata),
    .i_inv         (w_dacc_ack && r_we),
    .i_inv_addr    (r_addr),
    .i_lookup_addr (i_addr),
    .o_hit         (w_hit),
    .o_data        (w_buf_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    i_ready = w_hit | w_fetch_match;
    i_data  = '0;
    i_fault = 1'b0;
    d_ready = !w_dreq | w_dacc_ack;
    d_rdata = '0;
    d_fault = 1'b0;

    if (w_hit)              i_data = w_buf_data;
    else if (w_fetch_match) begin
      i_data  = mem_rdata;
      i_fault = mem_fault;
    end
    if (w_dacc_ack) begin
      d_rdata = mem_rdata;
      d_fault = mem_fault;
    end

    unique case (r_state)
      IDLE: begin
        w_grant = 1'b1;
        if (w_dreq)       w_next = DACC;
        else if (w_imiss) w_next = IFETCH;
      end
      IFETCH: begin
        mem_re = 1'b1;
        if (mem_ack) begin
          w_grant = 1'b1;
          if (w_dreq)       w_next = DACC;
          else if (w_imiss) w_next = IFETCH;
          else              w_next = IDLE;
        end
      end
      DACC: begin
        mem_re = r_re;
        mem_we = r_we;
        // The data strobe on the ack cycle is the request being retired.
        if (mem_ack) begin
          w_grant = 1'b1;
          w_next  = w_imiss ? IFETCH : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_re    <= 1'b0;
      r_we    <= 1'b0;
    end else if (w_grant) begin
      if (w_next == IFETCH) begin
        r_addr <= i_addr;
        r_re   <= 1'b1;
        r_we   <= 1'b0;
      end else if (w_next == DACC) begin
        r_addr  <= d_addr;
        r_wdata <= d_wdata;
        r_re    <= d_re;
        r_we    <= d_we;
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule
